ascon_ctrl_fsm: RTL

Parametrised Moore control unit for the ASCON-128 datapath. It sequences initialisation, a run-time number of associated-data (AD) and plaintext (PT) blocks, finalisation and tag output. It integrates the round counter and the block counter that were previously separate blocks. It replaces the fixed-block-count controller and drives the permutation, the key/data XOR bypasses and the output registers.

---
 rtl/ascon_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: Moore control unit for the ASCON-128 datapath.
// Sequences initialisation, a run-time number of AD and PT blocks,
// finalisation and tag output. The round counter and the block counter
// live here, next to the state register.
module ascon_ctrl_fsm #(
    parameter int PA         = 12,
    parameter int PB         = 6,
    parameter int MAX_BLOCKS = 15,
    parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] nb_ad_i,
    input  logic [CNT_W-1:0] nb_pt_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             data_sel_o,
    output logic [3:0]       round_o,
    output logic             perm_en_o,
    output logic             init_state_o,
    output logic             xor_data_o,
    output logic             xor_key_begin_o,
    output logic             xor_key_end_o,
    output logic             xor_dsep_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic [CNT_W-1:0] block_idx_o,
    output logic             busy_o,
    output logic             err_o
);

    // First round index of a PA / PB permutation; every permutation ends at 11.
    localparam logic [3:0]   ROUND_A   = 4'(12 - PA);
    localparam logic [3:0]   ROUND_B   = 4'(12 - PB);
    localparam logic [3:0]   ROUND_END = 4'd11;
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_BLOCKS);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        INIT_PERM,
        AD_WAIT,
        AD_PERM,
        PT_WAIT,
        PT_PERM,
        FINAL_PERM,
        TAG
    } state_t;

    state_t           state;
    logic [3:0]       round_q;
    logic [CNT_W-1:0] block_q;
    logic [CNT_W-1:0] nb_ad_q;
    logic [CNT_W-1:0] nb_pt_q;
    logic             err_q;

    logic counts_ok;
    logic last_round;
    logic last_ad;
    logic last_pt;

    assign counts_ok  = (nb_pt_i != '0) &&
                        ({1'b0, nb_pt_i} <= MAX_CNT) &&
                        ({1'b0, nb_ad_i} <= MAX_CNT);
    assign last_round = (round_q == ROUND_END);
    assign last_ad    = (block_q == nb_ad_q - CNT_W'(1));
    assign last_pt    = (block_q == nb_pt_q - CNT_W'(1));

    // State register together with the round counter, block counter,
    // latched message geometry and the rejected-start flag.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            round_q <= '0;
            block_q <= '0;
            nb_ad_q <= '0;
            nb_pt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    block_q <= '0;
                    if (start_i) begin
                        if (counts_ok) begin
                            nb_ad_q <= nb_ad_i;
                            nb_pt_q <= nb_pt_i;
                            state   <= INIT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    round_q <= ROUND_A;
                    state   <= INIT_PERM;
                end
                INIT_PERM: begin
                    if (last_round) begin
                        block_q <= '0;
                        state   <= (nb_ad_q != '0) ? AD_WAIT : PT_WAIT;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                AD_WAIT: begin
                    if (data_valid_i) begin
                        round_q <= ROUND_B;
                        state   <= AD_PERM;
                    end
                end
                AD_PERM: begin
                    if (last_round) begin
                        if (last_ad) begin
                            block_q <= '0;
                            state   <= PT_WAIT;
                        end else begin
                            block_q <= block_q + CNT_W'(1);
                            state   <= AD_WAIT;
                        end
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                PT_WAIT: begin
                    if (data_valid_i) begin
                        if (last_pt) begin
                            round_q <= ROUND_A;
                            state   <= FINAL_PERM;
                        end else begin
                            round_q <= ROUND_B;
                            state   <= PT_PERM;
                        end
                    end
                end
                PT_PERM: begin
                    if (last_round) begin
                        block_q <= block_q + CNT_W'(1);
                        state   <= PT_WAIT;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                FINAL_PERM: begin
                    if (last_round) begin
                        block_q <= '0;
                        state   <= TAG;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                TAG: begin
                    round_q <= '0;
                    block_q <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode: only registered state and counters feed the outputs.
    always_comb begin
        data_ready_o    = 1'b0;
        data_sel_o      = 1'b0;
        round_o         = '0;
        perm_en_o       = 1'b0;
        init_state_o    = 1'b0;
        xor_data_o      = 1'b0;
        xor_key_begin_o = 1'b0;
        xor_key_end_o   = 1'b0;
        xor_dsep_o      = 1'b0;
        cipher_valid_o  = 1'b0;
        tag_valid_o     = 1'b0;
        block_idx_o     = block_q;
        busy_o          = (state != IDLE);
        err_o           = err_q;
        case (state)
            INIT: begin
                init_state_o = 1'b1;
            end
            INIT_PERM: begin
                perm_en_o     = 1'b1;
                round_o       = round_q;
                xor_key_end_o = last_round;
                xor_dsep_o    = last_round && (nb_ad_q == '0);
            end
            AD_WAIT: begin
                data_ready_o = 1'b1;
            end
            AD_PERM: begin
                perm_en_o  = 1'b1;
                round_o    = round_q;
                xor_data_o = (round_q == ROUND_B);
                xor_dsep_o = last_round && last_ad;
            end
            PT_WAIT: begin
                data_ready_o = 1'b1;
                data_sel_o   = 1'b1;
            end
            PT_PERM: begin
                perm_en_o      = 1'b1;
                round_o        = round_q;
                xor_data_o     = (round_q == ROUND_B);
                cipher_valid_o = (round_q == ROUND_B);
            end
            FINAL_PERM: begin
                perm_en_o       = 1'b1;
                round_o         = round_q;
                xor_data_o      = (round_q == ROUND_A);
                cipher_valid_o  = (round_q == ROUND_A);
                xor_key_begin_o = (round_q == ROUND_A);
                xor_key_end_o   = last_round;
            end
            TAG: begin
                tag_valid_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
